bn_layer_sequencer: RTL and testbench

- Sequences one shared, pipelined batch-normalization compute unit over a feature map held in memory, filter by filter.
- Per filter, it fetches the precomputed scale/shift pair, then streams every element of that filter through the BN unit. Results are written back in place.
- Replaces the fully parallel BN layer when area is limited. Element order matches the layer's flattened packing: index = f*DEPTH*INPUT*INPUT + j*INPUT + k.

---
 rtl/bn_layer_sequencer.sv | 158 +++++++++++++++
 tb/tb_bn_layer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_layer_sequencer.sv
// Batch-normalization layer sequencer.
// Drives one shared, pipelined BN unit over a feature map, filter by filter:
// it fetches each filter's scale/shift pair, then streams every element of
// that filter through the unit and writes the results back to the same
// addresses in the feature memory.
module bn_layer_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FILTERS        = 64,
  parameter int DEPTH          = 1,
  parameter int INPUT          = 30,
  parameter int BN_LATENCY     = 4,
  parameter int ADDR_WIDTH     = 16,
  parameter int PRM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fm_rd_en,
  output logic [ADDR_WIDTH-1:0]     fm_rd_addr,
  input  logic [DATA_WIDTH-1:0]     fm_rd_data,
  output logic                      prm_rd_en,
  output logic [PRM_ADDR_WIDTH-1:0] prm_rd_addr,
  input  logic [2*DATA_WIDTH-1:0]   prm_rd_data,
  output logic                      bn_in_valid,
  output logic [DATA_WIDTH-1:0]     bn_in_data,
  output logic [DATA_WIDTH-1:0]     bn_scale,
  output logic [DATA_WIDTH-1:0]     bn_shift,
  input  logic                      bn_out_valid,
  input  logic [DATA_WIDTH-1:0]     bn_out_data,
  output logic                      fm_wr_en,
  output logic [ADDR_WIDTH-1:0]     fm_wr_addr,
  output logic [DATA_WIDTH-1:0]     fm_wr_data
);

  // Elements per filter and over the whole map.
  localparam int                        N_ELEM = DEPTH * INPUT * INPUT;
  localparam logic [ADDR_WIDTH-1:0]     E_LAST = ADDR_WIDTH'(N_ELEM - 1);
  localparam logic [ADDR_WIDTH-1:0]     TOTAL  = ADDR_WIDTH'(FILTERS * N_ELEM);
  localparam logic [PRM_ADDR_WIDTH-1:0] F_LAST = PRM_ADDR_WIDTH'(FILTERS - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_PARAM = 3'd1;
  localparam logic [2:0] S_PARAM_WAIT = 3'd2;
  localparam logic [2:0] S_STREAM     = 3'd3;
  localparam logic [2:0] S_DRAIN      = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  logic [2:0]                state;
  logic [PRM_ADDR_WIDTH-1:0] filt;      // current filter index
  logic [ADDR_WIDTH-1:0]     elem;      // element index inside the filter
  logic [ADDR_WIDTH-1:0]     rd_addr;   // running f*N+e read address
  logic [ADDR_WIDTH-1:0]     wr_cnt;    // results written so far in this run
  logic [DATA_WIDTH-1:0]     scale_q;
  logic [DATA_WIDTH-1:0]     shift_q;
  logic                      issue_q;   // read data is valid this cycle
  logic                      accept_start;
  logic                      accept_result;

  assign accept_start  = (state == S_IDLE) && start;
  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign accept_result = busy && bn_out_valid && (wr_cnt != TOTAL);

  // Control FSM: parameter fetch, element stream, drain of the BN pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      filt    <= '0;
      elem    <= '0;
      rd_addr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block
      // sampling them on this edge sees the pre-edge value.
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD_PARAM;
            filt    <= '0;
            elem    <= '0;
            rd_addr <= '0;
          end
        end
        S_LOAD_PARAM: state <= S_PARAM_WAIT;
        S_PARAM_WAIT: state <= S_STREAM;
        S_STREAM: begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
          if (elem == E_LAST) begin
            elem <= '0;
            if (filt == F_LAST) begin
              state <= S_DRAIN;
            end else begin
              filt  <= filt + PRM_ADDR_WIDTH'(1);
              state <= S_LOAD_PARAM;
            end
          end else begin
            elem <= elem + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (wr_cnt == TOTAL) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the filter's scale/shift as the parameter read data arrives.
  // The previous filter's last element is issued during LOAD_PARAM, before
  // this update, so it still sees its own parameters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_q <= '0;
      shift_q <= '0;
    end else if (state == S_PARAM_WAIT) begin
      scale_q <= prm_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
      shift_q <= prm_rd_data[DATA_WIDTH-1:0];
    end
  end

  // Feature read data returns one cycle after the strobe; mark that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_q <= 1'b0;
    else        issue_q <= (state == S_STREAM);
  end

  // Register BN results into the write port, in order, up to TOTAL writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      fm_wr_en   <= 1'b0;
      fm_wr_addr <= '0;
      fm_wr_data <= '0;
    end else begin
      fm_wr_en <= accept_result;
      if (accept_start) begin
        wr_cnt <= '0;
      end else if (accept_result) begin
        fm_wr_addr <= wr_cnt;
        fm_wr_data <= bn_out_data;
        wr_cnt     <= wr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  assign done        = (state == S_DONE);
  assign fm_rd_en    = (state == S_STREAM);
  assign fm_rd_addr  = fm_rd_en ? rd_addr : '0;
  assign prm_rd_en   = (state == S_LOAD_PARAM);
  assign prm_rd_addr = prm_rd_en ? filt : '0;
  assign bn_in_valid = issue_q;
  // Gate the memory data so the BN input is quiet whenever nothing is issued.
  assign bn_in_data  = issue_q ? fm_rd_data : '0;
  assign bn_scale    = scale_q;
  assign bn_shift    = shift_q;

endmodule

// File: tb/tb_bn_layer_sequencer.sv
// Self-checking bench for bn_layer_sequencer: memories and a BN unit
// (out = in*scale + shift) are modelled here; a per-cycle checker derives the
// expected port activity from the schedule arithmetic of the layer.
module tb_bn_layer_sequencer;

  localparam int DW      = 32;
  localparam int F       = 2;
  localparam int D       = 1;
  localparam int I       = 2;
  localparam int L       = 3;
  localparam int AW      = 16;
  localparam int PAW     = 6;
  localparam int N       = D * I * I;
  localparam int TOTAL   = F * N;
  localparam int PER     = N + 2;
  localparam int LAST_RD = F * PER;
  localparam int DONE_C  = LAST_RD + 3 + L;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic            fm_rd_en;
  logic [AW-1:0]   fm_rd_addr;
  logic [DW-1:0]   fm_rd_data;
  logic            prm_rd_en;
  logic [PAW-1:0]  prm_rd_addr;
  logic [2*DW-1:0] prm_rd_data;
  logic            bn_in_valid;
  logic [DW-1:0]   bn_in_data;
  logic [DW-1:0]   bn_scale;
  logic [DW-1:0]   bn_shift;
  logic            bn_out_valid;
  logic [DW-1:0]   bn_out_data;
  logic            fm_wr_en;
  logic [AW-1:0]   fm_wr_addr;
  logic [DW-1:0]   fm_wr_data;

  bn_layer_sequencer #(
    .DATA_WIDTH(DW), .FILTERS(F), .DEPTH(D), .INPUT(I), .BN_LATENCY(L),
    .ADDR_WIDTH(AW), .PRM_ADDR_WIDTH(PAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
    .prm_rd_en(prm_rd_en), .prm_rd_addr(prm_rd_addr), .prm_rd_data(prm_rd_data),
    .bn_in_valid(bn_in_valid), .bn_in_data(bn_in_data),
    .bn_scale(bn_scale), .bn_shift(bn_shift),
    .bn_out_valid(bn_out_valid), .bn_out_data(bn_out_data),
    .fm_wr_en(fm_wr_en), .fm_wr_addr(fm_wr_addr), .fm_wr_data(fm_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  int t0 = 0;
  int done_c = -1;
  int wr_seen = 0;
  int late_seen = 0;
  bit model_on = 0;
  logic inj = 1'b0;

  logic [DW-1:0] fm_mem [TOTAL];
  logic [DW-1:0] orig   [TOTAL];
  logic [DW-1:0] scl    [F];
  logic [DW-1:0] shf    [F];
  logic [DW-1:0] fm_rd_q;
  logic [2*DW-1:0] prm_q;

  // ---------- float helpers (normal numbers and zero only) ----------
  function automatic real sp_to_real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] bn_f(input logic [31:0] x, input logic [31:0] s,
                                       input logic [31:0] h);
    return real_to_sp(sp_to_real(x) * sp_to_real(s) + sp_to_real(h));
  endfunction

  function automatic logic [31:0] int_sp(input int v);
    return real_to_sp(real'(v));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------- environment: memories and BN unit ----------
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (fm_rd_en && fm_rd_addr < AW'(TOTAL)) fm_rd_q <= fm_mem[fm_rd_addr];
    if (prm_rd_en && prm_rd_addr < PAW'(F)) prm_q <= {scl[prm_rd_addr], shf[prm_rd_addr]};
    if (fm_wr_en) begin
      wr_seen = wr_seen + 1;
      if (fm_wr_addr < AW'(TOTAL)) fm_mem[fm_wr_addr] = fm_wr_data;
    end
    if (bn_out_valid && !rst_n) late_seen = late_seen + 1;
  end
  assign fm_rd_data  = fm_rd_q;
  assign prm_rd_data = prm_q;

  logic          pv [L];
  logic [DW-1:0] pd [L];
  always @(posedge clk) begin
    pv[0] <= bn_in_valid;
    pd[0] <= bn_f(bn_in_data, bn_scale, bn_shift);
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign bn_out_valid = pv[L-1] | inj;
  assign bn_out_data  = pd[L-1];

  // ---------- schedule model ----------
  // Cycle c (1-based after the start edge) reads element a if it falls in the
  // streaming part of a filter's N+2 cycle slot.
  function automatic bit rd_at(input int c, output int a);
    int pos;
    a = 0;
    if (c < 1 || c > LAST_RD) return 1'b0;
    pos = (c - 1) % PER;
    if (pos < 2) return 1'b0;
    a = ((c - 1) / PER) * N + pos - 2;
    return 1'b1;
  endfunction

  always @(negedge clk) begin : cmp
    int c, a;
    bit e;
    if (model_on) begin
      c = edge_cnt - t0 + 1;
      if (done) done_c = c;
      check("busy", 64'(busy), 64'(c >= 1 && c <= LAST_RD + 2 + L));
      check("done", 64'(done), 64'(c == DONE_C));
      e = rd_at(c, a);
      check("rd_en", 64'(fm_rd_en), 64'(e));
      if (e) check("rd_addr", 64'(fm_rd_addr), 64'(a));
      e = (c >= 1 && c <= LAST_RD && (c - 1) % PER == 0);
      check("prm_en", 64'(prm_rd_en), 64'(e));
      if (e) check("prm_addr", 64'(prm_rd_addr), 64'((c - 1) / PER));
      e = rd_at(c - 1, a);
      check("bn_valid", 64'(bn_in_valid), 64'(e));
      if (e) begin
        check("bn_data", 64'(bn_in_data), 64'(orig[a]));
        check("bn_scale", 64'(bn_scale), 64'(scl[a / N]));
        check("bn_shift", 64'(bn_shift), 64'(shf[a / N]));
      end
      e = rd_at(c - 2 - L, a);
      check("wr_en", 64'(fm_wr_en), 64'(e));
      if (e) begin
        check("wr_addr", 64'(fm_wr_addr), 64'(a));
        check("wr_data", 64'(fm_wr_data), 64'(bn_f(orig[a], scl[a / N], shf[a / N])));
      end
    end
  end

  // ---------- stimulus helpers ----------
  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) fm_mem[i] = int_sp(int'($urandom_range(0, 16)) - 8);
    for (int f = 0; f < F; f++) begin
      scl[f] = int_sp(int'($urandom_range(0, 6)) - 3);
      shf[f] = int_sp(int'($urandom_range(0, 10)) - 5);
    end
  endtask

  // One full run checked cycle by cycle; optional extra start pulse at pulse_at.
  task automatic run_model(input int pulse_at);
    for (int i = 0; i < TOTAL; i++) orig[i] = fm_mem[i];
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = edge_cnt; wr_seen = 0; done_c = -1; model_on = 1;
    for (int c = 1; c <= DONE_C + 3; c++) begin
      start = (c == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    model_on = 0;
    check("done_cycle", 64'(done_c), 64'(DONE_C));
    check("write_count", 64'(wr_seen), 64'(TOTAL));
    for (int i = 0; i < TOTAL; i++)
      check("mem_final", 64'(fm_mem[i]), 64'(bn_f(orig[i], scl[i / N], shf[i / N])));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_rd_en"}, 64'(fm_rd_en), 64'(0));
    check({tag, "_rd_addr"}, 64'(fm_rd_addr), 64'(0));
    check({tag, "_prm_en"}, 64'(prm_rd_en), 64'(0));
    check({tag, "_prm_addr"}, 64'(prm_rd_addr), 64'(0));
    check({tag, "_bn_valid"}, 64'(bn_in_valid), 64'(0));
    check({tag, "_bn_data"}, 64'(bn_in_data), 64'(0));
    check({tag, "_bn_scale"}, 64'(bn_scale), 64'(0));
    check({tag, "_bn_shift"}, 64'(bn_shift), 64'(0));
    check({tag, "_wr_en"}, 64'(fm_wr_en), 64'(0));
    check({tag, "_wr_addr"}, 64'(fm_wr_addr), 64'(0));
    check({tag, "_wr_data"}, 64'(fm_wr_data), 64'(0));
  endtask

  // ---------- main sequence ----------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < TOTAL; i++) fm_mem[i] = '0;
    for (int f = 0; f < F; f++) begin scl[f] = '0; shf[f] = '0; end
    repeat (L + 2) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // 4.0*2.0+1.0 = 9.0 everywhere, done at cycle 18.
    for (int i = 0; i < TOTAL; i++) fm_mem[i] = 32'h40800000;
    for (int f = 0; f < F; f++) begin scl[f] = 32'h40000000; shf[f] = 32'h3F800000; end
    run_model(-1);
    check("lit_done18", 64'(done_c), 64'(18));
    check("lit_writes8", 64'(wr_seen), 64'(8));
    for (int i = 0; i < TOTAL; i++) check("lit_nine", 64'(fm_mem[i]), 64'(32'h41100000));

    // Parameter switch at the filter boundary.
    fill_random();
    scl[0] = 32'h3F800000; shf[0] = 32'h00000000;
    scl[1] = 32'h00000000; shf[1] = 32'h40400000;
    run_model(-1);
    for (int i = 0; i < N; i++) check("lit_f0_same", 64'(fm_mem[i]), 64'(orig[i]));
    for (int i = N; i < TOTAL; i++) check("lit_f1_three", 64'(fm_mem[i]), 64'(32'h40400000));

    // Start pulse in the middle of a run is ignored.
    fill_random();
    run_model(5);
    check("lit_pulse_done18", 64'(done_c), 64'(18));

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_model(-1);
    end

    // Reset during STREAM of filter 1 (cycle 12), results still in flight.
    fill_random();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    late_seen = 0;
    #1 check_all_zero("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < L + 3; k++) begin
      @(negedge clk);
      if (bn_out_valid) late_seen++;
      check("late_no_wr", 64'(fm_wr_en), 64'(0));
      check("late_no_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
    end
    check("late_result_present", 64'(late_seen > 0), 64'(1));
    fill_random();
    run_model(-1);

    // Spurious BN results while idle.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      inj = (k < 3);
      @(negedge clk);
      check("idle_no_wr", 64'(fm_wr_en), 64'(0));
      check("idle_no_busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
    end
    inj = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
